// File: rtl/screen_sequencer.sv
// Game-level screen sequencer: START/PLAY/LOST/OVER phases, lives and frame-aligned colour select.
// Optional PAUSE state is enabled with `define SCREEN_SEQUENCER_PAUSE_EN.
module screen_sequencer #(
    parameter int unsigned INIT_LIVES   = 3,
    parameter int unsigned FLASH_FRAMES = 60,
    parameter int unsigned FLASH_PERIOD = 8,
    parameter int unsigned OVER_FRAMES  = 120
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       startButton,
    input  logic       ballLost,
`ifdef SCREEN_SEQUENCER_PAUSE_EN
    input  logic       pauseButton,
`endif
    input  logic [7:0] RGB_screen_main,
    input  logic [7:0] RGB_screen_start,
    input  logic [7:0] RGB_screen_over,
    output logic [7:0] RGB_screen,
    output logic       gameActive,
    output logic [1:0] lives,
    output logic       flashOn
);

    localparam int unsigned CntMax = (OVER_FRAMES > FLASH_FRAMES) ? OVER_FRAMES : FLASH_FRAMES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    typedef enum logic [2:0] {
        StStart,
        StPlay,
        StLost,
        StOver,
        StPause
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [1:0]        lives_q, lives_d;
    logic              start_prev_q;
    logic              start_pend_q, start_pend_d;
    logic              lost_pend_q, lost_pend_d;
    logic              flash_q, flash_d;
    logic              active_q, active_d;
    logic [7:0]        rgb_q, rgb_d;
    logic              start_evt, lost_evt;

`ifdef SCREEN_SEQUENCER_PAUSE_EN
    logic              pause_prev_q;
    logic              pause_pend_q, pause_pend_d;
    logic              pause_evt;
    logic [7:0]        dim_main;

    assign pause_evt = pause_pend_q | (pauseButton & ~pause_prev_q);
    assign dim_main  = {1'b0, RGB_screen_main[7:6], 1'b0, RGB_screen_main[4:3],
                        1'b0, RGB_screen_main[1]};
`endif

    // Events arriving in the startOfFrame cycle itself still count for that frame edge.
    assign start_evt = start_pend_q | (startButton & ~start_prev_q);
    assign lost_evt  = lost_pend_q | ballLost;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lives_d      = lives_q;
        start_pend_d = start_evt;
        lost_pend_d  = lost_evt;
`ifdef SCREEN_SEQUENCER_PAUSE_EN
        pause_pend_d = pause_evt;
`endif
        if (startOfFrame) begin
            start_pend_d = 1'b0;
            lost_pend_d  = 1'b0;
`ifdef SCREEN_SEQUENCER_PAUSE_EN
            pause_pend_d = 1'b0;
`endif
            unique case (state_q)
                StStart: begin
                    if (start_evt) begin
                        state_d = StPlay;
                        lives_d = 2'(INIT_LIVES);
                    end
                end
                StPlay: begin
                    if (lost_evt) begin
                        cnt_d = '0;
                        if (lives_q > 2'd1) begin
                            lives_d = lives_q - 2'd1;
                            state_d = StLost;
                        end else begin
                            lives_d = 2'd0;
                            state_d = StOver;
                        end
                    end
`ifdef SCREEN_SEQUENCER_PAUSE_EN
                    else if (pause_evt) begin
                        state_d = StPause;
                    end
`endif
                end
                StLost: begin
                    if (cnt_q == CntW'(FLASH_FRAMES - 1)) begin
                        state_d = StPlay;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StOver: begin
                    // Counter saturates so the start gate stays open indefinitely.
                    if (cnt_q >= CntW'(OVER_FRAMES)) begin
                        if (start_evt) begin
                            state_d = StStart;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef SCREEN_SEQUENCER_PAUSE_EN
                StPause: begin
                    if (pause_evt) state_d = StPlay;
                end
`endif
                default: state_d = StStart;
            endcase
        end
    end

    always_comb begin
        flash_d  = (state_d == StLost) && (((32'(cnt_d) / FLASH_PERIOD) % 2) == 1);
        active_d = (state_d == StPlay) || (state_d == StPause);
        unique case (state_q)
            StStart: rgb_d = RGB_screen_start;
            StPlay:  rgb_d = RGB_screen_main;
            StLost:  rgb_d = flash_q ? 8'hFF : RGB_screen_main;
            StOver:  rgb_d = RGB_screen_over;
`ifdef SCREEN_SEQUENCER_PAUSE_EN
            StPause: rgb_d = dim_main;
`endif
            default: rgb_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= StStart;
            cnt_q        <= '0;
            lives_q      <= 2'(INIT_LIVES);
            start_prev_q <= 1'b0;
            start_pend_q <= 1'b0;
            lost_pend_q  <= 1'b0;
            flash_q      <= 1'b0;
            active_q     <= 1'b0;
            rgb_q        <= 8'h00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lives_q      <= lives_d;
            start_prev_q <= startButton;
            start_pend_q <= start_pend_d;
            lost_pend_q  <= lost_pend_d;
            flash_q      <= flash_d;
            active_q     <= active_d;
            rgb_q        <= rgb_d;
        end
    end

`ifdef SCREEN_SEQUENCER_PAUSE_EN
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pause_prev_q <= 1'b0;
            pause_pend_q <= 1'b0;
        end else begin
            pause_prev_q <= pauseButton;
            pause_pend_q <= pause_pend_d;
        end
    end
`endif

    assign RGB_screen = rgb_q;
    assign gameActive = active_q;
    assign lives      = lives_q;
    assign flashOn    = flash_q;

endmodule
